// File: rtl/pmp_csr_file_pkg.sv
// Shared PMP types, CSR address map and the cfg WARL write rule.
package pmp_csr_file_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  localparam logic [11:0] PMPCFG_BASE   = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE  = 12'h3B0;
  localparam logic [7:0]  CFG_WARL_MASK = 8'h9F;

  // Reserved bits read as zero; W without R is reserved, so both drop to zero.
  function automatic pmp_cfg_t cfg_warl(input logic [7:0] wb);
    pmp_cfg_t c;
    c = pmp_cfg_t'(wb & CFG_WARL_MASK);
    if (c.w && !c.r) c.w = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pmp_napot_mask_gen.sv
// Registered NAPOT mask for one entry: trailing ones of addr plus the next bit cleared.
// Mask follows addr by one cycle; reloads only when en (addr just updated) is high.
module pmp_napot_mask_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] mask
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (en) begin
      mask <= ~(addr ^ (addr + 1'b1));
    end
  end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP cfg/addr CSR state with lock and WARL rules, plus registered NAPOT masks.
// Writes visible next cycle, masks one cycle later; reads return data one cycle after csr_rd_en.
module pmp_csr_file
  import pmp_csr_file_pkg::*;
#(
  parameter int PMP_CHANNEL_NUM = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_wr_en,
  input  logic                  csr_rd_en,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic                  csr_hit,
  output pmp_cfg_t              v_pmp_cfg        [PMP_CHANNEL_NUM],
  output logic [ADDR_WIDTH-1:0] v_pmp_addr       [PMP_CHANNEL_NUM],
  output logic [ADDR_WIDTH-1:0] v_pmp_napot_mask [PMP_CHANNEL_NUM],
  output logic                  pmp_stable
);

  localparam int CFG_REGS = PMP_CHANNEL_NUM / 4;

  logic                       cfg_hit;
  logic                       addr_hit;
  logic [11:0]                cfg_off;
  logic [11:0]                addr_off;
  logic [PMP_CHANNEL_NUM-1:0] addr_upd;
  logic [31:0]                rd_val;

  assign cfg_off  = csr_addr - PMPCFG_BASE;
  assign addr_off = csr_addr - PMPADDR_BASE;
  assign cfg_hit  = (csr_addr >= PMPCFG_BASE) && (csr_addr < PMPCFG_BASE + 12'(CFG_REGS));
  assign addr_hit = (csr_addr >= PMPADDR_BASE) && (csr_addr < PMPADDR_BASE + 12'(PMP_CHANNEL_NUM));
  assign csr_hit  = cfg_hit || addr_hit;

  for (genvar g = 0; g < PMP_CHANNEL_NUM; g++) begin : g_entry
    pmp_cfg_t              cfg_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  upd_r;
    logic                  tor_lock;
    logic                  cfg_we;
    logic                  addr_we;

    // A locked TOR entry above also freezes this entry's address (its lower bound).
    if (g < PMP_CHANNEL_NUM - 1) begin : g_tor
      assign tor_lock = v_pmp_cfg[g+1].l && (v_pmp_cfg[g+1].a == PMP_TOR);
    end else begin : g_last
      assign tor_lock = 1'b0;
    end

    assign cfg_we  = csr_wr_en && cfg_hit && (cfg_off == 12'(g / 4)) && !cfg_r.l;
    assign addr_we = csr_wr_en && addr_hit && (addr_off == 12'(g)) && !cfg_r.l && !tor_lock;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cfg_r  <= '0;
        addr_r <= '0;
        upd_r  <= 1'b0;
      end else begin
        if (cfg_we) cfg_r <= cfg_warl(csr_wdata[8*(g%4) +: 8]);
        if (addr_we) addr_r <= csr_wdata[ADDR_WIDTH-1:0];
        upd_r <= addr_we;
      end
    end

    assign v_pmp_cfg[g]  = cfg_r;
    assign v_pmp_addr[g] = addr_r;
    assign addr_upd[g]   = upd_r;

    pmp_napot_mask_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd_r),
      .addr  (addr_r),
      .mask  (v_pmp_napot_mask[g])
    );
  end

  assign pmp_stable = ~|addr_upd;

  always_comb begin
    rd_val = '0;
    for (int e = 0; e < PMP_CHANNEL_NUM; e++) begin
      if (cfg_hit && (cfg_off == 12'(e / 4))) rd_val[8*(e%4) +: 8] = v_pmp_cfg[e];
      if (addr_hit && (addr_off == 12'(e))) begin
        rd_val = '0;
        rd_val[ADDR_WIDTH-1:0] = v_pmp_addr[e];
      end
    end
  end

  // Sampling pre-edge state gives read-old-value on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_rd_en;
      csr_rdata  <= csr_rd_en ? rd_val : '0;
    end
  end

endmodule

// File: doc/pmp_csr_file.md
Name: pmp_csr_file

Overview:
Holds the PMP configuration and address CSR state for the core and drives the per-entry cfg, address and NAPOT-mask vectors consumed by pmp_compare. It sits directly upstream of the compare stage, on the CSR write/read path from the execute unit. It enforces lock and WARL rules and precomputes the NAPOT mask in a registered stage, so the compare path contains no mask arithmetic.

Parameters:
PMP_CHANNEL_NUM, 32, number of PMP entries; multiple of 4, maximum 64.
ADDR_WIDTH, 32, width of each pmpaddr register and mask (word-address units, addr>>2).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
csr_wr_en  in  1  CSR write strobe, single cycle
csr_rd_en  in  1  CSR read strobe, single cycle
csr_addr  in  12  CSR address
csr_wdata  in  32  write data (already merged for CSRRS/CSRRC upstream)
csr_rdata  out  32  read data, valid on the cycle after csr_rd_en
csr_rvalid  out  1  read-data valid pulse
csr_hit  out  1  combinational: csr_addr decodes to a PMP CSR
v_pmp_cfg  out  pmp_cfg_t[PMP_CHANNEL_NUM]  per-entry cfg
v_pmp_addr  out  ADDR_WIDTH[PMP_CHANNEL_NUM]  per-entry pmpaddr
v_pmp_napot_mask  out  ADDR_WIDTH[PMP_CHANNEL_NUM]  per-entry NAPOT mask
pmp_stable  out  1  low for the cycle in which any mask is being recomputed

Behaviour:
- Reset: all cfg = 8'h00 (A=OFF, L=0), all addr = 0, all masks = all-ones, csr_rdata = 0, csr_rvalid = 0, pmp_stable = 1.
- Decode: pmpcfgN at 0x3A0+N for N < PMP_CHANNEL_NUM/4; each holds entries 4N..4N+3, with byte k mapping to entry 4N+k. pmpaddrI at 0x3B0+I for I < PMP_CHANNEL_NUM. All other addresses give csr_hit = 0, are ignored on write and read as 0.
- Write to cfg (per byte, independently):
  - Skip the byte if that entry's L=1.
  - Bits [6:5] are stored as 0.
  - W=1 with R=0 is reserved; store R=0, W=0 and keep the other written fields.
- Write to pmpaddrI is dropped if either:
  - entry I has L=1, or
  - entry I+1 has L=1 and A=TOR (only checked when I+1 < PMP_CHANNEL_NUM).
- Write latency: a cfg or addr write is visible on v_pmp_cfg / v_pmp_addr the cycle after csr_wr_en.
- NAPOT mask:
  - mask[I] = ~(addr[I] ^ (addr[I]+1)), i.e. the trailing ones plus the next bit are cleared.
  - addr all-ones gives mask = 0.
  - Recomputed from the registered addr, and valid one cycle after the addr register updates (two cycles after the write).
  - Computed regardless of the A field; the compare stage uses it only for NAPOT. NA4 uses addr directly.
- pmp_stable: deasserted for exactly the one cycle between the addr update and the mask update after an accepted pmpaddr write. Dropped writes and cfg writes do not deassert it. Downstream holds fetch/LSU requests while it is low.
- Reads: csr_rdata and csr_rvalid are registered one cycle after csr_rd_en.
  - A cfg read returns the 4 packed bytes.
  - Concurrent read and write to the same address in the same cycle returns the old value.
  - Back-to-back reads are fully pipelined.
- csr_wr_en and csr_rd_en together on different addresses: both are performed.
- Reset mid-operation: asynchronous clear to the reset values, including any pending mask recompute and read pulse.
- L bit is sticky until reset; there is no other way to clear it.

Decomposition:
- toy_pack: reuse pmp_cfg_t. Add the A-field encodings PMP_OFF/PMP_TOR/PMP_NA4/PMP_NAPOT, the CSR bases PMPCFG_BASE=12'h3A0 and PMPADDR_BASE=12'h3B0, and the cfg WARL write-mask constant.
- One sub-module: pmp_napot_mask_gen, a registered per-entry mask generator (input addr, output mask; its enable is the per-entry addr-updated pulse). It is instantiated in a generate loop.

Test Plan:
- Reset, then read 0x3A0 and 0x3B0 -> rdata = 0 one cycle later, rvalid pulses; all masks = 32'hFFFFFFFF; pmp_stable = 1.
- Write pmpaddr0 = 32'h2000_01FF -> v_pmp_addr[0] updates at +1; at +2 v_pmp_napot_mask[0] = 32'hFFFF_FC00; pmp_stable is low only at +1.
- Write pmpcfg0 = 32'h0000_0082 (entry0 L=1, R=0, W=1) -> stored byte = 8'h80; then write pmpaddr0 = 0 and pmpcfg0 = 0 -> both unchanged, and pmp_stable stays 1.
- Set entry1 cfg = 8'h88 (L=1, TOR) -> a later write to pmpaddr0 is dropped; a write to pmpaddr2 succeeds.
- Read and write of 0x3B3 in the same cycle, old value 5, new value 9 -> rdata = 5, and a following read returns 9.
- Write to 0x3A9 when PMP_CHANNEL_NUM = 32 -> csr_hit = 0, no state change, reads as 0.
